// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the dual_clk_fifo write port among NUM_REQ producers.
// Optional WARB_STALL_CNT_EN adds a saturating stall_cnt output.
module fifo_wr_arbiter #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned DATESIZE  = 8,
    parameter int unsigned MAX_BURST = 4,
    localparam int unsigned IDXW     = $clog2(NUM_REQ)
) (
    input  logic                         wclk,
    input  logic                         wrst_n,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*DATESIZE-1:0]  req_data,
    output logic [NUM_REQ-1:0]           gnt,
    input  logic                         wfull,
    input  logic                         almost_full,
    output logic                         winc,
    output logic [DATESIZE-1:0]          wdata,
    output logic [IDXW-1:0]              cur_owner,
`ifdef WARB_STALL_CNT_EN
    output logic [15:0]                  stall_cnt,
`endif
    output logic                         busy
);

    localparam int unsigned BCW = $clog2(MAX_BURST + 1);

    typedef enum logic {StIdle, StBurst} state_e;

    state_e                r_state, w_state_d;
    logic [IDXW-1:0]       r_owner, w_owner_d;
    logic [IDXW-1:0]       r_last, w_last_d;
    logic [BCW-1:0]        r_beat_cnt, w_beat_d;
    logic                  r_winc;
    logic [DATESIZE-1:0]   r_wdata, w_wdata_d;

    logic                  w_own_req;
    logic [DATESIZE-1:0]   w_own_data;
    logic                  w_accept;
    logic                  w_burst_end;
    logic [NUM_REQ-1:0]    w_others;
    logic [IDXW:0]         w_pick_idle;
    logic [IDXW:0]         w_pick_next;

    // First set bit of mask scanning upward from start with wrap; MSB flags a hit.
    function automatic logic [IDXW:0] f_pick(input logic [NUM_REQ-1:0] mask,
                                             input int unsigned start);
        logic [IDXW:0] res;
        int unsigned   j;
        res = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            j = start + k;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (!res[IDXW] && mask[j]) res = {1'b1, IDXW'(j)};
        end
        return res;
    endfunction

    always_comb begin
        w_own_data = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (r_owner == IDXW'(i)) w_own_data = req_data[i*DATESIZE +: DATESIZE];
        end
    end

    assign w_own_req = req[r_owner];
    // An in-flight write plus almost_full means the FIFO's last slot is already taken.
    assign w_accept  = wrst_n && (r_state == StBurst) && w_own_req && !wfull
                       && !(almost_full && r_winc);
    assign w_burst_end = (r_state == StBurst)
                         && ((w_accept && (r_beat_cnt == BCW'(MAX_BURST - 1))) || !w_own_req);
    assign w_others    = req & ~(NUM_REQ'(1) << r_owner);
    assign w_pick_idle = f_pick(req, 32'(r_last) + 32'd1);
    assign w_pick_next = f_pick(w_others, 32'(r_owner) + 32'd1);

    always_comb begin
        gnt = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            gnt[i] = w_accept && (r_owner == IDXW'(i));
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_owner_d = r_owner;
        w_last_d  = r_last;
        w_beat_d  = r_beat_cnt;
        w_wdata_d = w_accept ? w_own_data : r_wdata;
        unique case (r_state)
            StIdle: begin
                if (|req) begin
                    w_owner_d = w_pick_idle[IDXW-1:0];
                    w_beat_d  = '0;
                    w_state_d = StBurst;
                end
            end
            StBurst: begin
                if (w_accept) w_beat_d = r_beat_cnt + BCW'(1);
                if (w_burst_end) begin
                    w_last_d = r_owner;
                    w_beat_d = '0;
                    if (w_pick_next[IDXW]) begin
                        w_owner_d = w_pick_next[IDXW-1:0];
                    end else begin
                        w_state_d = StIdle;
                    end
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            r_state    <= StIdle;
            r_owner    <= '0;
            r_last     <= IDXW'(NUM_REQ - 1);
            r_beat_cnt <= '0;
            r_winc     <= 1'b0;
            r_wdata    <= '0;
        end else begin
            r_state    <= w_state_d;
            r_owner    <= w_owner_d;
            r_last     <= w_last_d;
            r_beat_cnt <= w_beat_d;
            r_winc     <= w_accept;
            r_wdata    <= w_wdata_d;
        end
    end

`ifdef WARB_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            r_stall_cnt <= '0;
        end else if ((r_state == StBurst) && w_own_req && !w_accept
                     && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

    assign winc      = r_winc;
    assign wdata     = r_wdata;
    assign cur_owner = r_owner;
    assign busy      = (r_state == StBurst);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: reset, round robin, single requester, stalls, throttle.
module tb_fifo_wr_arbiter;

    logic        wclk;
    logic        wrst_n;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  gnt;
    logic        wfull;
    logic        almost_full;
    logic        winc;
    logic [7:0]  wdata;
    logic [1:0]  cur_owner;
    logic        busy;
`ifdef WARB_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    int          n_vec;
    int          n_fail;
    int          d;
    logic [7:0]  base;
    logic [7:0]  prev_wd;

    fifo_wr_arbiter #(
        .NUM_REQ   (4),
        .DATESIZE  (8),
        .MAX_BURST (4)
    ) dut (
        .wclk        (wclk),
        .wrst_n      (wrst_n),
        .req         (req),
        .req_data    (req_data),
        .gnt         (gnt),
        .wfull       (wfull),
        .almost_full (almost_full),
        .winc        (winc),
        .wdata       (wdata),
        .cur_owner   (cur_owner),
`ifdef WARB_STALL_CNT_EN
        .stall_cnt   (stall_cnt),
`endif
        .busy        (busy)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge wclk);
        #1;
    endtask

    task automatic do_reset();
        wrst_n      = 1'b0;
        wfull       = 1'b0;
        almost_full = 1'b0;
        tick();
        tick();
        wrst_n  = 1'b1;
        d       = 0;
        prev_wd = 8'h00;
    endtask

    // One cycle: requester r offers base+d; check gnt, then the registered write.
    task automatic beat(input string tag, input int r, input logic [3:0] exp_g);
        req_data[r*8 +: 8] = base + 8'(d);
        #1;
        chk({tag, "_gnt"}, 32'(gnt), 32'(exp_g));
        tick();
        chk({tag, "_winc"}, 32'(winc), 32'(exp_g != 4'b0));
        if (exp_g != 4'b0) begin
            chk({tag, "_wdata"}, 32'(wdata), 32'(base + 8'(d)));
            prev_wd = base + 8'(d);
            d++;
        end else begin
            chk({tag, "_hold"}, 32'(wdata), 32'(prev_wd));
        end
    endtask

    initial begin
        n_vec       = 0;
        n_fail      = 0;
        d           = 0;
        base        = 8'h00;
        prev_wd     = 8'h00;
        wrst_n      = 1'b0;
        wfull       = 1'b0;
        almost_full = 1'b0;
        req         = 4'b1111;
        req_data    = 32'hA3A2A1A0;

        // Reset held for two edges with everyone requesting.
        #1;
        chk("rst_gnt_pre", 32'(gnt), 32'h0);
        tick();
        tick();
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_winc", 32'(winc), 32'h0);
        chk("rst_wdata", 32'(wdata), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_owner", 32'(cur_owner), 32'h0);
        wrst_n = 1'b1;
        #1;
        chk("idle_gnt", 32'(gnt), 32'h0);
        tick();
        chk("burst_busy", 32'(busy), 32'h1);

        // Round robin: four beats each from 0,1,2,3 then back to 0.
        for (int k = 0; k < 17; k++) begin
            int o;
            o = (k / 4) % 4;
            chk("rr_gnt", 32'(gnt), 32'(4'b0001 << o));
            chk("rr_owner", 32'(cur_owner), 32'(o));
            tick();
            chk("rr_winc", 32'(winc), 32'h1);
            chk("rr_wdata", 32'(wdata), 32'(8'hA0 + 8'(o)));
        end

        // Reset mid-burst: the beat offered this cycle is dropped.
        wrst_n = 1'b0;
        #1;
        chk("mid_rst_gnt", 32'(gnt), 32'h0);
        tick();
        chk("mid_rst_winc", 32'(winc), 32'h0);
        chk("mid_rst_busy", 32'(busy), 32'h0);
        chk("mid_rst_wdata", 32'(wdata), 32'h0);

        // Single requester 2 streaming 0x10..0x17; one idle gap after every burst.
        req  = 4'b0100;
        base = 8'h10;
        tick();
        wrst_n  = 1'b1;
        d       = 0;
        prev_wd = 8'h00;
        for (int c = 0; c < 10; c++) begin
            beat("single", 2, (c == 0 || c == 5) ? 4'b0000 : 4'b0100);
        end
        chk("single_count", 32'(d), 32'd8);

        // Full stall at beat_cnt=2 for owner 1, then resume with the last two beats.
        req  = 4'b0010;
        base = 8'h20;
        do_reset();
        for (int c = 0; c < 8; c++) begin
            wfull = (c == 3 || c == 4);
            beat("full", 1, (c == 0 || c == 3 || c == 4 || c == 7) ? 4'b0000 : 4'b0010);
            if (c == 3) chk("full_owner", 32'(cur_owner), 32'd1);
        end
        chk("full_count", 32'(d), 32'd4);
        wfull = 1'b0;

        // Almost-full throttle: blocked while a write is in flight, else one beat.
        req  = 4'b0001;
        base = 8'h30;
        do_reset();
        beat("af0", 0, 4'b0000);
        beat("af1", 0, 4'b0001);
        almost_full = 1'b1;
        beat("af2", 0, 4'b0000);
        beat("af3", 0, 4'b0001);
        beat("af4", 0, 4'b0000);
`ifdef WARB_STALL_CNT_EN
        chk("af_stall_cnt", 32'(stall_cnt), 32'd2);
`endif
        almost_full = 1'b0;

        // Owner dropping req costs one cycle, then the next requester takes over.
        req  = 4'b0011;
        base = 8'h40;
        do_reset();
        beat("drop0", 0, 4'b0000);
        beat("drop1", 0, 4'b0001);
        req = 4'b0010;
        beat("drop2", 1, 4'b0000);
        chk("drop_owner", 32'(cur_owner), 32'd1);
        chk("drop_busy", 32'(busy), 32'h1);
        beat("drop3", 1, 4'b0010);

`ifdef WARB_STALL_CNT_EN
        // Ten full cycles in BURST, then reset clears the counter.
        req  = 4'b0010;
        do_reset();
        tick();
        wfull = 1'b1;
        repeat (10) tick();
        chk("stall_cnt10", 32'(stall_cnt), 32'd10);
        wrst_n = 1'b0;
        tick();
        chk("stall_cnt_rst", 32'(stall_cnt), 32'd0);
        chk("stall_busy_rst", 32'(busy), 32'h0);
        wrst_n = 1'b1;
        wfull  = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
